// File: rtl/seletor_pkg.sv
// Shared definitions for the arbitrated channel selector: mode encodings and
// the circular index helper used by the round-robin scan.
package seletor_pkg;

    localparam logic MODO_FIXO = 1'b0;
    localparam logic MODO_RR   = 1'b1;

    function automatic int unsigned prox_idx(input int unsigned i, input int unsigned n);
        return (i + 32'd1 >= n) ? 32'd0 : i + 32'd1;
    endfunction

endpackage

// File: rtl/seletor_arbitrado_arbitro_rr.sv
// Combinational round-robin arbiter: scans from the channel after ptr,
// wrapping around, and returns the first valid channel.
module arbitro_rr
    import seletor_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valido,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          tem_grant
);

    logic [SW-1:0] idx_s;
    logic [SW-1:0] grant_s;
    logic          found_s;

    // Rotate-and-priority-encode; ptr itself is visited last so it only wins alone.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        idx_s   = SW'(prox_idx(int'(ptr), N));
        for (int k = 0; k < N; k++) begin
            grant_s = (!found_s && valido[idx_s]) ? idx_s : grant_s;
            found_s = found_s | valido[idx_s];
            idx_s   = SW'(prox_idx(int'(idx_s), N));
        end
    end

    assign grant     = grant_s;
    assign tem_grant = found_s;

endmodule

// File: rtl/seletor_arbitrado.sv
// N-to-1 channel selector with valid/ready handshakes, a single-entry output
// register, and fixed (SEL) or round-robin channel selection.
module seletor_arbitrado
    import seletor_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N*W-1:0]  ENTRADAS,
    input  logic [N-1:0]    VALIDO,
    output logic [N-1:0]    ACEITO,
    input  logic            MODO,
    input  logic [SW-1:0]   SEL,
    output logic [W-1:0]    SAIDA,
    output logic [SW-1:0]   ORIGEM,
    output logic            SAIDA_VALIDA,
    input  logic            SAIDA_PRONTA
);

    logic [W-1:0]  saida_r;
    logic [SW-1:0] origem_r;
    logic          valida_r;
    logic [SW-1:0] ptr_r;

    logic [SW-1:0] rr_grant_s;
    logic          rr_ok_s;
    logic [SW-1:0] cand_s;
    logic          cand_ok_s;
    logic          livre_s;
    logic          captura_s;
    logic [N-1:0]  aceito_s;

    arbitro_rr #(.N(N), .SW(SW)) u_arbitro (
        .valido    (VALIDO),
        .ptr       (ptr_r),
        .grant     (rr_grant_s),
        .tem_grant (rr_ok_s)
    );

    // Mode mux and capture decision; reset suppresses any grant.
    always_comb begin
        cand_s    = '0;
        cand_ok_s = 1'b0;
        aceito_s  = '0;
        case (MODO)
            MODO_FIXO: begin
                cand_s    = SEL;
                cand_ok_s = VALIDO[SEL];
            end
            MODO_RR: begin
                cand_s    = rr_grant_s;
                cand_ok_s = rr_ok_s;
            end
            default: begin
                cand_s    = '0;
                cand_ok_s = 1'b0;
            end
        endcase
        livre_s   = !valida_r || SAIDA_PRONTA;
        captura_s = !reset && livre_s && cand_ok_s;
        if (captura_s) begin
            aceito_s = {{(N-1){1'b0}}, 1'b1} << cand_s;
        end else begin
            aceito_s = '0;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            saida_r  <= '0;
            origem_r <= '0;
            valida_r <= 1'b0;
            ptr_r    <= SW'(N - 1);
        end else if (captura_s) begin
            saida_r  <= ENTRADAS[cand_s*W +: W];
            origem_r <= cand_s;
            valida_r <= 1'b1;
            ptr_r    <= cand_s;
        end else if (livre_s) begin
            valida_r <= 1'b0;
        end else begin
            valida_r <= valida_r;
        end
    end

    assign ACEITO       = aceito_s;
    assign SAIDA        = saida_r;
    assign ORIGEM       = origem_r;
    assign SAIDA_VALIDA = valida_r;

endmodule

// File: tb/tb_seletor_arbitrado.sv
// Directed bench for seletor_arbitrado (N=8, W=4) with hand-computed expectations.
module tb_seletor_arbitrado;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int SW = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*W-1:0]  ENTRADAS;
    logic [N-1:0]    VALIDO;
    logic [N-1:0]    ACEITO;
    logic            MODO;
    logic [SW-1:0]   SEL;
    logic [W-1:0]    SAIDA;
    logic [SW-1:0]   ORIGEM;
    logic            SAIDA_VALIDA;
    logic            SAIDA_PRONTA;

    int n_tests = 0;
    int n_fail  = 0;

    seletor_arbitrado #(.N(N), .W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ENTRADAS     (ENTRADAS),
        .VALIDO       (VALIDO),
        .ACEITO       (ACEITO),
        .MODO         (MODO),
        .SEL          (SEL),
        .SAIDA        (SAIDA),
        .ORIGEM       (ORIGEM),
        .SAIDA_VALIDA (SAIDA_VALIDA),
        .SAIDA_PRONTA (SAIDA_PRONTA)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic [2:0] o, input logic v);
        chk({tag, "_saida"}, 32'(SAIDA), 32'(d));
        chk({tag, "_origem"}, 32'(ORIGEM), 32'(o));
        chk({tag, "_valida"}, 32'(SAIDA_VALIDA), 32'(v));
    endtask

    initial begin
        reset        = 1'b1;
        ENTRADAS     = 32'h7654_3210;
        VALIDO       = 8'hFF;
        MODO         = 1'b1;
        SEL          = 3'd0;
        SAIDA_PRONTA = 1'b1;

        // reset held two cycles with all channels valid
        tick();
        chk("rst_aceito1", 32'(ACEITO), 32'h0);
        tick();
        chk("rst_aceito2", 32'(ACEITO), 32'h0);
        chk_out("rst", 4'h0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_first_grant", 32'(ACEITO), 32'h01);

        // round-robin fairness over 10 words
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_out($sformatf("rr%0d", k), 4'(k % 8), 3'(k % 8), 1'b1);
        end

        // fixed mode
        MODO     = 1'b0;
        SEL      = 3'd5;
        VALIDO   = 8'h20;
        ENTRADAS = 32'h76A4_3210;
        #1;
        chk("fix_aceito", 32'(ACEITO), 32'h20);
        tick();
        chk_out("fix_cap", 4'hA, 3'd5, 1'b1);
        SEL = 3'd3;
        #1;
        chk("fix_nocand", 32'(ACEITO), 32'h0);
        tick();
        chk_out("fix_drain", 4'hA, 3'd5, 1'b0);

        // wrap and sparse valids (ptr=5 now)
        MODO     = 1'b1;
        ENTRADAS = 32'h7654_3210;
        VALIDO   = 8'h40;
        #1;
        chk("wrap_g6_aceito", 32'(ACEITO), 32'h40);
        tick();
        chk_out("wrap_g6", 4'h6, 3'd6, 1'b1);
        VALIDO = 8'b0000_0101;
        #1;
        chk("wrap_g0_aceito", 32'(ACEITO), 32'h01);
        tick();
        chk_out("wrap_g0", 4'h0, 3'd0, 1'b1);
        chk("wrap_g2_aceito", 32'(ACEITO), 32'h04);
        tick();
        chk_out("wrap_g2", 4'h2, 3'd2, 1'b1);
        VALIDO = 8'h40;
        #1;
        chk("only6_aceito", 32'(ACEITO), 32'h40);
        tick();
        chk_out("only6", 4'h6, 3'd6, 1'b1);
        chk("self_only_aceito", 32'(ACEITO), 32'h40);

        // backpressure: hold a word from channel 2 (ptr=6)
        VALIDO = 8'h04;
        #1;
        chk("bp_g2_aceito", 32'(ACEITO), 32'h04);
        tick();
        chk_out("bp_g2", 4'h2, 3'd2, 1'b1);
        SAIDA_PRONTA = 1'b0;
        VALIDO       = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_stall_aceito%0d", k), 32'(ACEITO), 32'h0);
            tick();
            chk_out($sformatf("bp_stall%0d", k), 4'h2, 3'd2, 1'b1);
        end
        SAIDA_PRONTA = 1'b1;
        #1;
        chk("bp_release_aceito", 32'(ACEITO), 32'h08);
        tick();
        chk_out("bp_release", 4'h3, 3'd3, 1'b1);

        // reset mid-operation while holding channel 4
        tick();
        chk_out("mid_g4", 4'h4, 3'd4, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_aceito", 32'(ACEITO), 32'h0);
        tick();
        chk_out("mid_rst", 4'h0, 3'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_after_aceito", 32'(ACEITO), 32'h01);
        tick();
        chk_out("mid_after", 4'h0, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seletor_arbitrado.md
Name: seletor_arbitrado

Overview:
- Parametrised N-to-1 channel selector with a registered output stage and a valid/ready handshake on every input and on the output.
- Two selection modes:
  - fixed: the channel is chosen by SEL, as in the existing combinational 8-to-1 selector.
  - round-robin: a fair arbiter picks among the channels that have valid data.
- Reports the source channel index (ORIGEM) alongside each output word.
- Sits between producer channels and a single consumer, and replaces the combinational selector wherever backpressure or fairness is needed.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 4, data width per channel.
- SW, $clog2(N), width of SEL and ORIGEM (derived; not overridden).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ENTRADAS  input  N*W  channel data, flattened; channel i occupies bits [i*W +: W].
- VALIDO  input  N  VALIDO[i]=1: channel i is presenting data.
- ACEITO  output  N  one-hot or zero; ACEITO[i]=1: channel i is consumed this cycle.
- MODO  input  1  0 = fixed (SEL), 1 = round-robin.
- SEL  input  SW  channel index used when MODO=0.
- SAIDA  output  W  registered output data.
- ORIGEM  output  SW  registered index of the channel that produced SAIDA.
- SAIDA_VALIDA  output  1  SAIDA/ORIGEM hold a word.
- SAIDA_PRONTA  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (reset=1 at a rising edge): SAIDA=0, ORIGEM=0, SAIDA_VALIDA=0, round-robin pointer ptr=N-1. ACEITO=0 during any reset cycle. Reset mid-transfer discards the held word, and no ACEITO is issued that cycle.
- Output stage: a single-entry register.
  - livre = !SAIDA_VALIDA || SAIDA_PRONTA, so a capture is allowed in the same cycle as a consume.
- Candidate selection, combinational, evaluated each cycle:
  - MODO=0: candidate = SEL if VALIDO[SEL]=1; otherwise no candidate.
  - MODO=1: candidate = first i with VALIDO[i]=1, scanning (ptr+1) mod N, (ptr+2) mod N, ..., ptr. Wrap-around is required. If ptr's own channel is the only valid one, it wins.
- Capture: if livre and a candidate exists:
  - ACEITO[candidate]=1 in that cycle.
  - At the next edge: SAIDA <= channel data, ORIGEM <= candidate, SAIDA_VALIDA <= 1, ptr <= candidate.
  - ptr updates in both modes.
- Drain without capture: if livre and no candidate, SAIDA_VALIDA <= 0 at the next edge. SAIDA and ORIGEM keep their last values (don't-care for the consumer).
- Stall: if SAIDA_VALIDA=1 and SAIDA_PRONTA=0:
  - ACEITO=0.
  - SAIDA, ORIGEM and SAIDA_VALIDA are held stable.
  - Inputs are not consumed.
- Latency and throughput: one cycle from ACEITO to SAIDA_VALIDA. Throughput is one word per cycle while SAIDA_PRONTA=1 continuously.
- ACEITO is combinational from VALIDO, MODO, SEL, SAIDA_VALIDA, SAIDA_PRONTA and ptr. It never depends on ENTRADAS.
- Changes to MODO or SEL take effect at the next capture decision only; a word already held is unaffected.
- Producers must hold data stable while VALIDO=1 until ACEITO. The block does not check this.
- Fairness in MODO=1: with all N channels valid continuously and SAIDA_PRONTA=1, grants cycle through 0,1,...,N-1,0,... No channel waits more than N-1 grants.

Decomposition:
- Shared package seletor_pkg: mode constants MODO_FIXO=1'b0 and MODO_RR=1'b1; a helper function for the next-index wrap, (i+1) mod N.
- One natural sub-module, arbitro_rr (parameter N):
  - inputs: VALIDO vector, ptr.
  - outputs: grant index, grant-exists flag.
  - purely combinational rotate-and-priority-encode.
- The top level holds ptr, the output register and the mode mux.

Test Plan (N=8, W=4):
- Reset: hold reset=1 for 2 cycles with VALIDO=8'hFF -> ACEITO=0, SAIDA_VALIDA=0, SAIDA=0, ORIGEM=0. In the first cycle after release, ACEITO=8'h01.
- Fixed mode: MODO=0, SEL=5, channel 5 data=4'hA, VALIDO=8'h20, SAIDA_PRONTA=1 -> ACEITO=8'h20. Next cycle SAIDA=4'hA, ORIGEM=5, SAIDA_VALIDA=1. With SEL=3 and VALIDO=8'h20 -> ACEITO=0, and SAIDA_VALIDA drops the cycle after the consume.
- Round-robin fairness: MODO=1, VALIDO=8'hFF held, channel i data=i, SAIDA_PRONTA=1 for 10 cycles -> ORIGEM sequence 0,1,2,3,4,5,6,7,0,1 with SAIDA equal to ORIGEM.
- Wrap and sparse valids: MODO=1, ptr=6 (after a grant to 6), VALIDO=8'b0000_0101 -> grants 0 then 2. With VALIDO=8'h40 only -> grant 6 again.
- Backpressure: a word from channel 2 is held; SAIDA_PRONTA=0 for 3 cycles with VALIDO=8'hFF -> ACEITO=0 and SAIDA/ORIGEM stable for all 3 cycles. In the cycle SAIDA_PRONTA=1 -> ACEITO=8'h08, with capture and consume in the same cycle.
- Reset mid-operation: SAIDA_VALIDA=1 holding channel 4, reset pulsed 1 cycle -> SAIDA_VALIDA=0, ptr restored. Next grant with VALIDO=8'hFF is channel 0.
